// File: rtl/dot_accumulator.sv
// Dot-product accumulator: sums signed carry-save beats into a saturating
// accumulator and holds each finished result in a single output buffer.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   S_IDLE  | no partial sum; acc and cnt are zero
//   S_ACCUM | partial sum of the current dot product held
//   S_HOLD  | result presented on outputs, waiting for ready
module dot_accumulator #(
    parameter  int IN_SIZE_0 = 4,
    parameter  int IN_SIZE_1 = 8,
    parameter  int ACC_EXTRA = 16,
    localparam int IN_W      = IN_SIZE_0 + IN_SIZE_1 + 8,
    localparam int ACC_W     = IN_W + ACC_EXTRA
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [0:1][IN_W-1:0]    in_i,
    input  logic                    in_last_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic signed [ACC_W-1:0] out_o,
    output logic [15:0]             out_cnt_o,
    output logic                    out_sat_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_HOLD
    } state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              sticky_q, sticky_d;
    logic [ACC_W-1:0]  out_q, out_d;
    logic [15:0]       out_cnt_q, out_cnt_d;
    logic              out_sat_q, out_sat_d;

    logic [IN_W-1:0]   beat_sum;
    logic [ACC_W-1:0]  beat_ext;
    logic [ACC_W:0]    sum_wide;
    logic              ovf;
    logic [ACC_W-1:0]  sat_val;
    logic [15:0]       cnt_inc;
    logic              sticky_nx;

    // The compressor pair is resolved modulo 2^IN_W, then treated as signed.
    assign beat_sum  = in_i[0] + in_i[1];
    assign beat_ext  = {{ACC_EXTRA{beat_sum[IN_W-1]}}, beat_sum};
    assign sum_wide  = {acc_q[ACC_W-1], acc_q} + {beat_ext[ACC_W-1], beat_ext};
    assign ovf       = sum_wide[ACC_W] != sum_wide[ACC_W-1];
    assign sat_val   = ovf ? (sum_wide[ACC_W] ? ACC_MIN : ACC_MAX) : sum_wide[ACC_W-1:0];
    assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign sticky_nx = sticky_q | ovf;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            sticky_q  <= 1'b0;
            out_q     <= '0;
            out_cnt_q <= '0;
            out_sat_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sticky_q  <= sticky_d;
            out_q     <= out_d;
            out_cnt_q <= out_cnt_d;
            out_sat_q <= out_sat_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sticky_d  = sticky_q;
        out_d     = out_q;
        out_cnt_d = out_cnt_q;
        out_sat_d = out_sat_q;
        case (state_q)
            S_IDLE, S_ACCUM: begin
                if (in_valid_i) begin
                    if (in_last_i) begin
                        out_d     = sat_val;
                        out_cnt_d = cnt_inc;
                        out_sat_d = sticky_nx;
                        acc_d     = '0;
                        cnt_d     = '0;
                        sticky_d  = 1'b0;
                        state_d   = S_HOLD;
                    end else begin
                        acc_d    = sat_val;
                        cnt_d    = cnt_inc;
                        sticky_d = sticky_nx;
                        state_d  = S_ACCUM;
                    end
                end
            end
            // No beat is taken here, so ready only returns the cycle after release.
            S_HOLD: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready_o  = (state_q != S_HOLD);
    assign out_valid_o = (state_q == S_HOLD);
    assign out_o       = out_q;
    assign out_cnt_o   = out_cnt_q;
    assign out_sat_o   = out_sat_q;

endmodule

// File: tb/tb_dot_accumulator.sv
// Self-checking bench for dot_accumulator: directed scenarios plus random
// traffic compared against an arithmetic reference model.
module tb_dot_accumulator;

    localparam int IN_W  = 20;
    localparam int ACC_W = 36;
    localparam longint ACC_MAXV = (longint'(1) <<< 35) - 1;
    localparam longint ACC_MINV = -(longint'(1) <<< 35);

    logic                    clk_i = 1'b0;
    logic                    rst_i = 1'b1;
    logic                    in_valid_i = 1'b0;
    logic                    in_ready_o;
    logic [0:1][IN_W-1:0]    in_i = '0;
    logic                    in_last_i = 1'b0;
    logic                    out_valid_o;
    logic                    out_ready_i = 1'b0;
    logic signed [ACC_W-1:0] out_o;
    logic [15:0]             out_cnt_o;
    logic                    out_sat_o;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit     m_hold;
    longint m_acc;
    int     m_cnt;
    bit     m_sticky;
    longint m_out;
    int     m_ocnt;
    bit     m_osat;

    dot_accumulator dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_i        (in_i),
        .in_last_i   (in_last_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_o       (out_o),
        .out_cnt_o   (out_cnt_o),
        .out_sat_o   (out_sat_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic longint beat_val(input int a0, input int a1);
        longint s;
        s = (longint'(a0) + longint'(a1)) & longint'(64'hFFFFF);
        if (s >= 524288) s -= 1048576;
        return s;
    endfunction

    task automatic model_reset();
        m_hold = 0; m_acc = 0; m_cnt = 0; m_sticky = 0;
        m_out = 0; m_ocnt = 0; m_osat = 0;
    endtask

    task automatic model_edge(input bit v, input int a0, input int a1, input bit last, input bit ordy);
        longint s;
        int c;
        if (m_hold) begin
            if (ordy) m_hold = 0;
        end else if (v) begin
            s = m_acc + beat_val(a0, a1);
            if (s > ACC_MAXV) begin s = ACC_MAXV; m_sticky = 1; end
            if (s < ACC_MINV) begin s = ACC_MINV; m_sticky = 1; end
            c = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
            if (last) begin
                m_out = s; m_ocnt = c; m_osat = m_sticky;
                m_acc = 0; m_cnt = 0; m_sticky = 0; m_hold = 1;
            end else begin
                m_acc = s; m_cnt = c;
            end
        end
    endtask

    // Drive one cycle: inputs applied #1 after an edge, outputs checked before the next edge.
    task automatic cycle(input bit v, input int a0, input int a1, input bit last, input bit ordy);
        in_valid_i  = v;
        in_i[0]     = IN_W'(a0);
        in_i[1]     = IN_W'(a1);
        in_last_i   = last;
        out_ready_i = ordy;
        #1;
        chk("in_ready", 64'(in_ready_o), 64'(!m_hold));
        chk("out_valid", 64'(out_valid_o), 64'(m_hold));
        if (m_hold) begin
            chk("out_o", out_o, m_out);
            chk("out_cnt", 64'(out_cnt_o), 64'(m_ocnt));
            chk("out_sat", 64'(out_sat_o), 64'(m_osat));
        end
        @(posedge clk_i);
        model_edge(v, a0, a1, last, ordy);
        #1;
    endtask

    task automatic apply_reset();
        in_valid_i = 0; out_ready_i = 0; in_last_i = 0;
        rst_i = 1;
        #1;
        chk("rst_in_ready", 64'(in_ready_o), 64'd1);
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_out_o", out_o, 64'd0);
        chk("rst_out_cnt", 64'(out_cnt_o), 64'd0);
        chk("rst_out_sat", 64'(out_sat_o), 64'd0);
        @(posedge clk_i);
        #1;
        rst_i = 0;
        model_reset();
    endtask

    initial begin
        model_reset();
        #2;
        apply_reset();

        // Three-beat product: 7 + (-1) + 8 = 14
        cycle(1, 3, 4, 0, 1);
        cycle(1, -1, 0, 0, 1);
        cycle(1, 10, -2, 1, 1);
        chk("r032_valid", 64'(out_valid_o), 64'd1);
        chk("r032_out", out_o, 64'd14);
        chk("r032_cnt", 64'(out_cnt_o), 64'd3);
        chk("r032_sat", 64'(out_sat_o), 64'd0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);

        // Beat wraps modulo 2^20 to the most negative value
        cycle(1, 524287, 1, 1, 1);
        chk("r033_out", out_o, -64'sd524288);
        chk("r033_cnt", 64'(out_cnt_o), 64'd1);
        cycle(0, 0, 0, 0, 1);

        // Back-pressure: hold 5 cycles with valid high, then release
        cycle(1, 2, 3, 0, 0);
        cycle(1, 4, 0, 1, 0);
        for (int i = 0; i < 5; i++) cycle(1, $urandom, $urandom, $urandom_range(0, 1), 0);
        chk("r035_out", out_o, 64'd9);
        cycle(1, 99, 0, 1, 1);
        chk("r035_ready_after_hs", 64'(in_ready_o), 64'd1);
        cycle(1, 5, 0, 1, 1);
        chk("r035_next_out", out_o, 64'd5);
        cycle(0, 0, 0, 0, 1);

        // Reset mid-accumulation discards partial sum
        cycle(1, 100, 0, 0, 1);
        cycle(1, 200, 0, 0, 1);
        apply_reset();
        cycle(1, 7, 0, 1, 0);
        chk("r036_out", out_o, 64'd7);
        chk("r036_cnt", 64'(out_cnt_o), 64'd1);
        // Reset while holding a result
        apply_reset();
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 1500; i++)
            cycle($urandom_range(0, 3) != 0, int'($urandom), int'($urandom),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1);

        // Positive saturation and count saturation
        for (int i = 0; i < 65600; i++) cycle(1, 524287, 0, 0, 1);
        cycle(1, 524287, 0, 1, 1);
        chk("r034_out", out_o, ACC_MAXV);
        chk("r034_sat", 64'(out_sat_o), 64'd1);
        chk("r034_cnt", 64'(out_cnt_o), 64'd65535);
        cycle(0, 0, 0, 0, 1);
        cycle(1, 1, 0, 1, 1);
        chk("r034_next_sat", 64'(out_sat_o), 64'd0);
        chk("r034_next_out", out_o, 64'd1);
        cycle(0, 0, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
